// File: rtl/regfile_reader.sv
// Sequential byte read-out of the register file onto a valid/ready stream.
// Optional trailing XOR checksum byte when REGFILE_READER_CSUM_EN is defined.
module regfile_reader #(
  parameter int BYTE_NUM = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] reg_rd_addr_o,
  input  logic [7:0] reg_rd_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o
);

  localparam logic [2:0] LAST_ADDR = 3'(BYTE_NUM - 1);

`ifdef REGFILE_READER_CSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_CSUM, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
`ifdef REGFILE_READER_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef REGFILE_READER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef REGFILE_READER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef REGFILE_READER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = '0;
`ifdef REGFILE_READER_CSUM_EN
          csum_d  = '0;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Register data is sampled only here, so later writes affect only unloaded bytes
        data_d  = reg_rd_data_i;
        valid_d = 1'b1;
`ifdef REGFILE_READER_CSUM_EN
        csum_d  = csum_q ^ reg_rd_data_i;
        last_d  = 1'b0;
`else
        last_d  = (addr_q == LAST_ADDR);
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (valid_q && out_ready_i) begin
          if (addr_q < LAST_ADDR) begin
            valid_d = 1'b0;
            addr_d  = addr_q + 3'd1;
            state_d = ST_LOAD;
          end else begin
`ifdef REGFILE_READER_CSUM_EN
            data_d  = csum_q;
            last_d  = 1'b1;
            state_d = ST_CSUM;
`else
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef REGFILE_READER_CSUM_EN
      ST_CSUM: begin
        if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign reg_rd_addr_o = addr_q;
  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_last_o    = last_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed self-checking bench for regfile_reader; honours REGFILE_READER_CSUM_EN.
module tb_regfile_reader;

  localparam int BN = 8;
`ifdef REGFILE_READER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic [2:0] reg_rd_addr_o;
  logic [7:0] reg_rd_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       out_last_o;

  logic [7:0] regs [8];
  logic [7:0] expb [9];
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;
  assign reg_rd_data_i = regs[reg_rd_addr_o];

  regfile_reader #(.BYTE_NUM(BN)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .reg_rd_addr_o (reg_rd_addr_o),
    .reg_rd_data_i (reg_rd_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_last_o    (out_last_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"},  32'(busy_o), 0);
    check_eq({tag, " done"},  32'(done_o), 0);
    check_eq({tag, " addr"},  32'(reg_rd_addr_o), 0);
    check_eq({tag, " valid"}, 32'(out_valid_o), 0);
    check_eq({tag, " data"},  32'(out_data_o), 0);
    check_eq({tag, " last"},  32'(out_last_o), 0);
  endtask

  // Called one delta after a rising edge with the DUT idle ("cycle 0").
  // sb/ss: stall byte and stall length; hold: keep start high; wc: cycle to write 0xFF.
  task automatic run_scan(input string name, input int sb, input int ss, input bit hold, input int wc);
    int vs [9];
    int vl [9];
    int nb;
    int done_c;
    int ei;
    bit ev;
    logic [7:0] cs;
    nb = BN + CS;
    cs = 8'h00;
    for (int j = 0; j < BN; j++) begin
      cs = cs ^ expb[j];
      vs[j] = 2 + 2 * j + ((ss > 0 && j > sb) ? ss : 0);
      vl[j] = (ss > 0 && j == sb) ? 1 + ss : 1;
    end
    expb[BN] = cs;
    vs[BN] = 2 * BN + 1 + ss;
    vl[BN] = 1;
    done_c = vs[nb-1] + vl[nb-1];
    start_i = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk_i); #1;
      if (!hold) start_i = 1'b0;
      ev = 1'b0;
      ei = 0;
      for (int j = 0; j < nb; j++)
        if (c >= vs[j] && c < vs[j] + vl[j]) begin
          ev = 1'b1;
          ei = j;
        end
      check_eq($sformatf("%s c%0d valid", name, c), 32'(out_valid_o), 32'(ev));
      check_eq($sformatf("%s c%0d busy", name, c), 32'(busy_o), 32'(c <= done_c));
      check_eq($sformatf("%s c%0d done", name, c), 32'(done_o), 32'(c == done_c));
      if (ev) begin
        check_eq($sformatf("%s c%0d data", name, c), 32'(out_data_o), 32'(expb[ei]));
        check_eq($sformatf("%s c%0d last", name, c), 32'(out_last_o), 32'(ei == nb - 1));
      end
      if (c == wc)
        for (int j = 0; j < 8; j++) regs[j] = 8'hFF;
      out_ready_i = !(ss > 0 && c >= vs[sb] && c < vs[sb] + ss);
    end
    if (hold) begin
      @(posedge clk_i); #1;
      check_eq({name, " restart busy"}, 32'(busy_o), 1);
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
  endtask

  task automatic set_regs_seq();
    for (int j = 0; j < 8; j++) begin
      regs[j] = 8'(j + 1);
      expb[j] = 8'(j + 1);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0;
    out_ready_i = 1'b1;
    set_regs_seq();
    #23;
    check_reset_outputs("por");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    run_scan("basic", 0, 0, 1'b0, -1);

    run_scan("bp", 3, 5, 1'b0, -1);

    for (int j = 0; j < 8; j++) expb[j] = (j <= 2) ? 8'(j + 1) : 8'hFF;
    run_scan("wr", 0, 0, 1'b0, 6);
    set_regs_seq();

    run_scan("hold", 0, 0, 1'b1, -1);
    pulse_reset("hold_rst");

    // Abort while byte 4 is valid (cycle 10)
    start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    check_eq("abort pre valid", 32'(out_valid_o), 1);
    check_eq("abort pre data", 32'(out_data_o), 32'h05);
    pulse_reset("abort");
    check_eq("abort post done", 32'(done_o), 0);
    run_scan("restart", 0, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential read-out engine for the byte register file. On a start pulse it walks register addresses 0 to BYTE_NUM-1 over the file's combinational read port. It delivers each byte on a valid/ready byte stream toward the host-side transmit path. It is the read-side counterpart of the 64-bit parallel register load.

## Interface
Parameters:
- BYTE_NUM, 8, bytes sent per scan; legal range 1..8; the address port stays 3 bits.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  scan request; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a scan completes.
- reg_rd_addr_o  out  3  register file read address (registered).
- reg_rd_data_i  in  8  register file read data; combinational from reg_rd_addr_o.
- out_valid_o  out  1  stream byte valid.
- out_ready_i  in  1  stream sink ready.
- out_data_o  out  8  stream byte.
- out_last_o  out  1  marks the final byte of a scan.

## Operation
- FSM states: IDLE, LOAD, SEND, CSUM (only with the macro), DONE.
- IDLE, start_i=1: addr<=0, csum<=0, go to LOAD. start_i is ignored in every other state.
- LOAD:
  - out_data_o<=reg_rd_data_i and out_valid_o<=1.
  - csum<=csum^reg_rd_data_i.
  - out_last_o<=(addr==BYTE_NUM-1) when CSUM is disabled, else 0.
  - Go to SEND.
- SEND: hold out_data_o, out_last_o and out_valid_o stable while out_valid_o && !out_ready_i. On handshake (valid && ready):
  - If addr<BYTE_NUM-1: out_valid_o<=0, addr<=addr+1, go to LOAD.
  - Else, CSUM enabled: out_data_o<=csum, out_last_o<=1, out_valid_o stays 1, go to CSUM.
  - Else: out_valid_o<=0, out_last_o<=0, go to DONE.
- CSUM: hold the byte until handshake; then out_valid_o<=0, out_last_o<=0, go to DONE.
- DONE: done_o=1 for exactly this cycle; go to IDLE.
- Address width rule: addr is 3 bits and never wraps; the last address is BYTE_NUM-1.
- Register writes during a scan: a byte is sampled in its LOAD cycle only. A mid-scan write therefore affects only bytes not yet loaded. This is legal, not an error.
- Reset mid-operation: all state clears immediately and asynchronously. A partially sent scan is abandoned with no last byte and no done_o.

## Timing
- Reset values: busy_o=0, done_o=0, reg_rd_addr_o=0, out_valid_o=0, out_data_o=8'h00, out_last_o=0. FSM=IDLE, csum=0.
- start_i high at edge 0 puts the FSM in LOAD in cycle 1. The first byte is valid in cycle 2.
- With out_ready_i held at 1, each byte occupies 2 cycles (LOAD plus SEND). Byte k is valid in cycle 2+2k.
- After the last handshake (including the checksum byte when enabled), DONE occupies one cycle; IDLE follows on the next cycle.
- With BYTE_NUM=8 and no backpressure:
  - CSUM disabled: byte 7 is valid in cycle 16, done_o is high in cycle 17, and IDLE returns in cycle 18.
  - CSUM enabled: the checksum is valid in cycle 17 and done_o is high in cycle 18.
- A start_i pulse in the DONE cycle is ignored. A start_i high in the first IDLE cycle is accepted.

## Configuration
- REGFILE_READER_CSUM_EN defined: CSUM state present.
  - One extra stream byte follows the last register byte.
  - The extra byte is the XOR of all BYTE_NUM bytes sent.
  - out_last_o is asserted only on the checksum byte.
- Undefined: no CSUM state and no csum register. out_last_o is asserted on byte BYTE_NUM-1.

## Test plan
- Registers 0x01..0x08, ready always 1, no macro, start at edge 0:
  - Bytes 01..08 are valid in cycles 2,4,…,16.
  - out_last_o is set only on 0x08.
  - done_o is high in cycle 17 only; busy_o is high in cycles 1..17.
- Same stimulus with REGFILE_READER_CSUM_EN: nine bytes, the last being 0x08 (XOR of 01..08) with out_last_o=1. done_o is high in cycle 18.
- Backpressure: out_ready_i=0 for 5 cycles while byte 3 is valid. out_data_o stays 0x04 and out_valid_o stays 1 throughout. The scan then resumes and total duration grows by exactly 5 cycles.
- Write 0xFF..FF to the register file while byte 2 is in SEND. Bytes 0..2 keep their old values and bytes 3..7 read 0xFF.
- start_i held high for a whole scan: exactly one scan runs, and a second scan starts in the first IDLE cycle after done_o.
- rst_n_i low while byte 4 is valid: all outputs read reset values immediately with no done_o. A fresh start_i restarts from address 0.
